// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results take priority; buffered loads drain into the free write slots.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AluValid,
  input  logic [4:0]  AluReg,
  input  logic [31:0] AluData,
  output logic        AluStall,
  input  logic        MemValid,
  output logic        MemReady,
  input  logic [4:0]  MemReg,
  input  logic [31:0] MemData,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic [31:0] PendingMask
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    mem_reg_q  [DEPTH];
  logic [4:0]    mem_reg_d  [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_data_d [DEPTH];
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_register_q, write_register_d;
  logic [31:0]   write_data_q, write_data_d;

  logic          full, empty, push, pop, alu_cand, alu_win, force_fifo;
  logic [AW:0]   count;
  logic [AW-1:0] offset;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign MemReady = !full;
  assign alu_cand = AluValid && (AluReg != 5'd0);
  // Loads to r0 complete the handshake but are never stored.
  assign push     = MemValid && !full && (MemReg != 5'd0);
  assign alu_win  = alu_cand && !force_fifo;
  assign pop      = !empty && !alu_win;

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          alu_stall_q, alu_stall_d;

  assign force_fifo = alu_stall_q;
  assign AluStall   = alu_stall_q;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    alu_stall_d  = 1'b0;
    if (pop) begin
      starve_cnt_d = '0;
    end else if (!empty && alu_win) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
      alu_stall_d  = (starve_cnt_d == CW'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      starve_cnt_q <= '0;
      alu_stall_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      alu_stall_q  <= alu_stall_d;
    end
  end
`else
  assign force_fifo = 1'b0;
  assign AluStall   = 1'b0;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    mem_reg_d  = mem_reg_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_reg_d[wr_ptr_q[AW-1:0]]  = MemReg;
      mem_data_d[wr_ptr_q[AW-1:0]] = MemData;
    end
  end

  always_comb begin
    reg_write_d      = 1'b0;
    write_register_d = 5'd0;
    write_data_d     = 32'd0;
    if (alu_win) begin
      reg_write_d      = 1'b1;
      write_register_d = AluReg;
      write_data_d     = AluData;
    end else if (pop) begin
      reg_write_d      = 1'b1;
      write_register_d = mem_reg_q[rd_ptr_q[AW-1:0]];
      write_data_d     = mem_data_q[rd_ptr_q[AW-1:0]];
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    PendingMask = 32'd0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - rd_ptr_q[AW-1:0];
      if ({1'b0, offset} < count) PendingMask[mem_reg_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      mem_reg_q        <= '{default: '0};
      mem_data_q       <= '{default: '0};
      reg_write_q      <= 1'b0;
      write_register_q <= 5'd0;
      write_data_q     <= 32'd0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      mem_reg_q        <= mem_reg_d;
      mem_data_q       <= mem_data_d;
      reg_write_q      <= reg_write_d;
      write_register_q <= write_register_d;
      write_data_q     <= write_data_d;
    end
  end

  assign RegWrite      = reg_write_q;
  assign WriteRegister = write_register_q;
  assign WriteData     = write_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; starvation scenario runs when WB_STARVE_GUARD_EN is defined.
module tb_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        AluValid = 1'b0;
  logic [4:0]  AluReg = '0;
  logic [31:0] AluData = '0;
  logic        AluStall;
  logic        MemValid = 1'b0;
  logic        MemReady;
  logic [4:0]  MemReg = '0;
  logic [31:0] MemData = '0;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] PendingMask;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluStall(AluStall),
    .MemValid(MemValid), .MemReady(MemReady), .MemReg(MemReg), .MemData(MemData),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .PendingMask(PendingMask)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    AluValid = 1'b0; AluReg = '0; AluData = '0;
    MemValid = 1'b0; MemReg = '0; MemData = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 Reset = 1'b1;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL rst_we got %0b want 0", RegWrite); end
    checks++; if (WriteRegister !== 5'd0) begin errors++; $display("[TB] FAIL rst_wreg got %0d want 0", WriteRegister); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("[TB] FAIL rst_wdata got %h want 0", WriteData); end
    checks++; if (MemReady !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %0b want 1", MemReady); end
    checks++; if (PendingMask !== 32'd0) begin errors++; $display("[TB] FAIL rst_mask got %h want 0", PendingMask); end
    checks++; if (AluStall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall got %0b want 0", AluStall); end
    step();
    @(negedge Clk) Reset = 1'b0;
    step();
  endtask

  task automatic test_alu_only();
    AluValid = 1'b1; AluReg = 5'd5; AluData = 32'hDEADBEEF;
    step();
    idle_inputs();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL alu_we got %0b want 1", RegWrite); end
    checks++; if (WriteRegister !== 5'd5) begin errors++; $display("[TB] FAIL alu_wreg got %0d want 5", WriteRegister); end
    checks++; if (WriteData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL alu_wdata got %h want deadbeef", WriteData); end
    checks++; if (AluStall !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall got %0b want 0", AluStall); end
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL alu_we_after got %0b want 0", RegWrite); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_mask;
    for (int i = 0; i < 4; i++) begin
      AluValid = 1'b1; AluReg = 5'd1; AluData = 32'h50 + i;
      MemValid = 1'b1; MemReg = 5'(8 + i); MemData = 32'h100 + i;
      step();
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd1 || WriteData !== 32'h50 + i)
        begin errors++; $display("[TB] FAIL fill_alu[%0d] got we=%0b reg=%0d data=%h want we=1 reg=1 data=%h", i, RegWrite, WriteRegister, WriteData, 32'h50 + i); end
    end
    idle_inputs();
    checks++; if (MemReady !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready got %0b want 0", MemReady); end
    checks++; if (PendingMask !== 32'h0000_0F00) begin errors++; $display("[TB] FAIL fill_mask got %h want 00000f00", PendingMask); end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_mask = (32'h0000_0F00 << (i + 1)) & 32'h0000_0F00;
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(8 + i) || WriteData !== 32'h100 + i)
        begin errors++; $display("[TB] FAIL drain[%0d] got we=%0b reg=%0d data=%h want we=1 reg=%0d data=%h", i, RegWrite, WriteRegister, WriteData, 8 + i, 32'h100 + i); end
      checks++; if (PendingMask !== exp_mask) begin errors++; $display("[TB] FAIL drain_mask[%0d] got %h want %h", i, PendingMask, exp_mask); end
    end
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL drain_done got we=%0b want 0", RegWrite); end
  endtask

  task automatic test_alu_r0();
    AluValid = 1'b1; AluReg = 5'd1; AluData = 32'h11;
    MemValid = 1'b1; MemReg = 5'd3; MemData = 32'h1234;
    step();
    checks++; if (PendingMask !== 32'h8) begin errors++; $display("[TB] FAIL r0_mask_q got %h want 00000008", PendingMask); end
    MemValid = 1'b0; AluReg = 5'd0; AluData = 32'hBAD;
    step();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 32'h1234)
      begin errors++; $display("[TB] FAIL r0_load got we=%0b reg=%0d data=%h want we=1 reg=3 data=00001234", RegWrite, WriteRegister, WriteData); end
    checks++; if (PendingMask !== 32'd0) begin errors++; $display("[TB] FAIL r0_mask_clr got %h want 0", PendingMask); end
    MemValid = 1'b1; MemReg = 5'd0; MemData = 32'h77;
    step();
    MemValid = 1'b0; AluValid = 1'b0;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL r0_alu_drop got we=%0b reg=%0d want we=0", RegWrite, WriteRegister); end
    checks++; if (PendingMask !== 32'd0 || MemReady !== 1'b1) begin errors++; $display("[TB] FAIL r0_mem_drop got mask=%h ready=%0b want mask=0 ready=1", PendingMask, MemReady); end
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL r0_no_write got we=%0b reg=%0d want we=0", RegWrite, WriteRegister); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_mask;
    for (int i = 0; i < 4; i++) begin
      AluValid = 1'b1; AluReg = 5'd2; AluData = 32'h60 + i;
      MemValid = 1'b1; MemReg = 5'(16 + i); MemData = 32'h200 + i;
      step();
    end
    AluValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      MemReg  = 5'(20 + ((i > 0) ? i - 1 : 0));
      MemData = 32'h200 + 32'(MemReg) - 32'd16;
      if (i == 0) begin
        checks++; if (MemReady !== 1'b0) begin errors++; $display("[TB] FAIL full_ready0 got %0b want 0", MemReady); end
      end
      step();
      exp_mask = 32'h7 << (17 + i);
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(16 + i) || WriteData !== 32'h200 + i)
        begin errors++; $display("[TB] FAIL pp_write[%0d] got we=%0b reg=%0d data=%h want reg=%0d data=%h", i, RegWrite, WriteRegister, WriteData, 16 + i, 32'h200 + i); end
      checks++; if (MemReady !== 1'b1) begin errors++; $display("[TB] FAIL pp_ready[%0d] got %0b want 1", i, MemReady); end
      checks++; if (PendingMask !== exp_mask) begin errors++; $display("[TB] FAIL pp_mask[%0d] got %h want %h", i, PendingMask, exp_mask); end
    end
    MemValid = 1'b0;
    for (int i = 6; i < 9; i++) begin
      step();
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(16 + i) || WriteData !== 32'h200 + i)
        begin errors++; $display("[TB] FAIL pp_drain[%0d] got we=%0b reg=%0d data=%h want reg=%0d data=%h", i, RegWrite, WriteRegister, WriteData, 16 + i, 32'h200 + i); end
    end
    step();
    checks++; if (RegWrite !== 1'b0 || PendingMask !== 32'd0) begin errors++; $display("[TB] FAIL pp_empty got we=%0b mask=%h want 0 0", RegWrite, PendingMask); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      AluValid = 1'b1; AluReg = 5'd1; AluData = 32'h70 + i;
      MemValid = 1'b1; MemReg = 5'(2 + 2 * i); MemData = 32'h300 + i;
      step();
    end
    checks++; if (PendingMask !== 32'h54) begin errors++; $display("[TB] FAIL mid_mask got %h want 00000054", PendingMask); end
    idle_inputs();
    Reset = 1'b1;
    #1;
    checks++; if (PendingMask !== 32'd0 || MemReady !== 1'b1 || RegWrite !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_rst got mask=%h ready=%0b we=%0b want 0 1 0", PendingMask, MemReady, RegWrite); end
    step();
    @(negedge Clk) Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (RegWrite !== 1'b0 || PendingMask !== 32'd0)
        begin errors++; $display("[TB] FAIL mid_after[%0d] got we=%0b mask=%h want 0 0", i, RegWrite, PendingMask); end
    end
  endtask

`ifdef WB_STARVE_GUARD_EN
  task automatic test_starve_guard();
    Reset = 1'b1;
    step();
    @(negedge Clk) Reset = 1'b0;
    step();
    MemValid = 1'b1; MemReg = 5'd9; MemData = 32'h9999;
    step();
    MemValid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      AluValid = 1'b1; AluReg = 5'd7; AluData = 32'hA0 + k;
      step();
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 32'hA0 + k)
        begin errors++; $display("[TB] FAIL sg_alu[%0d] got we=%0b reg=%0d data=%h want reg=7 data=%h", k, RegWrite, WriteRegister, WriteData, 32'hA0 + k); end
      checks++; if (AluStall !== (k == 8)) begin errors++; $display("[TB] FAIL sg_stall[%0d] got %0b want %0b", k, AluStall, k == 8); end
    end
    AluData = 32'hA9;
    step();
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 32'h9999)
      begin errors++; $display("[TB] FAIL sg_load got we=%0b reg=%0d data=%h want reg=9 data=00009999", RegWrite, WriteRegister, WriteData); end
    checks++; if (AluStall !== 1'b0) begin errors++; $display("[TB] FAIL sg_stall_clr got %0b want 0", AluStall); end
    step();
    AluValid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 32'hA9)
      begin errors++; $display("[TB] FAIL sg_held got we=%0b reg=%0d data=%h want reg=7 data=000000a9", RegWrite, WriteRegister, WriteData); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_only();
    test_fill_drain();
    test_alu_r0();
    test_full_push_pop();
    test_reset_midstream();
`ifdef WB_STARVE_GUARD_EN
    test_starve_guard();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back stage directly upstream of the register file.
- Merges two result sources onto the register file's single synchronous write port:
  - the single-cycle ALU path, which can never be stalled in the base configuration;
  - the multi-cycle load path, which uses a valid/ready handshake.
- Load results are buffered in a small FIFO, drained whenever the ALU is not writing.
- Exports a pending-destination mask so the hazard unit can stall readers of registers still waiting to be written.

Parameters:
- DEPTH, 4, load FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before the starvation guard fires (used only with WB_STARVE_GUARD_EN).

Ports:
- Clk  input  1  clock; all state updates on the positive edge.
- Reset  input  1  asynchronous, active-high reset.
- AluValid  input  1  ALU result present this cycle.
- AluReg  input  5  ALU destination register.
- AluData  input  32  ALU result.
- AluStall  output  1  ALU must hold its result (starvation guard only; tied 0 otherwise).
- MemValid  input  1  load result offered.
- MemReady  output  1  FIFO can accept a load result.
- MemReg  input  5  load destination register.
- MemData  input  32  load result.
- RegWrite  output  1  register file write enable (registered).
- WriteRegister  output  5  register file write address (registered).
- WriteData  output  32  register file write data (registered).
- PendingMask  output  32  bit r = 1 if any valid FIFO entry targets register r.

Behaviour:
- Clock and reset: one clock, Clk; reset is asynchronous and active-high, named Reset.
- Reset state (asynchronous):
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - FIFO empty, so MemReady=1 and PendingMask=0.
  - AluStall=0; starvation counter cleared.
- Reset mid-operation discards all buffered loads; no partial write is issued.
- Handshake and push:
  - MemReady = !full, combinational from state only; it never depends on MemValid.
  - A load is accepted on an edge where MemValid&MemReady=1.
  - An accepted load with MemReg=0 is consumed but not enqueued.
- Arbitration, evaluated each cycle:
  - ALU candidate = AluValid && AluReg!=0.
  - If there is an ALU candidate, the ALU wins.
  - Otherwise, if the FIFO is non-empty, the FIFO head wins and is popped on that edge.
  - Otherwise there is no write.
  - AluValid with AluReg=0 is discarded silently and frees the slot for the FIFO.
- Latency: the winner is registered onto RegWrite/WriteRegister/WriteData at the next edge. The register file commits it one edge later. Selection to output is 1 cycle; source to register file contents is 2 cycles.
- RegWrite is never 1 with WriteRegister=0.
- Push and pop in the same edge:
  - Both occur; occupancy is unchanged.
  - Allowed only when not full before the edge.
  - Push into an empty FIFO cannot be popped in the same cycle; the earliest pop is the following cycle.
- Ordering:
  - The FIFO is strictly in-order.
  - No ordering is enforced between the ALU and load sources; the hazard unit uses PendingMask.
- PendingMask: combinational OR-decode of valid entry destinations. Duplicate destinations are permitted; a bit clears only when no valid entry remains for that register.
- Pointers are log2(DEPTH) bits plus one wrap bit. Full = pointers match with wrap bits differing; empty = pointers identical.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Enabled:
  - A counter increments each cycle the FIFO is non-empty and the ALU wins; it clears on any FIFO pop.
  - When the count reaches STARVE_LIMIT, AluStall=1 (registered) for exactly one cycle.
  - In that cycle the FIFO head wins regardless of AluValid; the ALU must hold its inputs.
  - The counter then clears.
- Disabled:
  - AluStall is constant 0, the counter is absent, and the ALU always has priority.

Test Plan:
- Reset asserted mid-stream with 3 loads queued: next cycle PendingMask=0, MemReady=1, RegWrite=0, and no write follows after deassert.
- ALU only, AluReg=5, AluData=0xDEADBEEF in cycle N: RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF in cycle N+1; RegWrite=0 in cycle N+2.
- Four loads to r8..r11 pushed with the ALU busy every cycle: MemReady=0 after the 4th; PendingMask=0x00000F00. When the ALU idles, writes appear in order r8, r9, r10, r11 on consecutive cycles, and the mask clears bit by bit.
- ALU to r0 with one load (r3, 0x1234) queued: the load is written the next cycle; r0 never appears with RegWrite=1.
- FIFO full, ALU idle, MemValid held: push and pop on the same edge never overflow; MemReady is asserted one cycle after the first pop.
- With WB_STARVE_GUARD_EN, STARVE_LIMIT=8, one load queued, ALU valid every cycle: after 8 ALU writes, AluStall=1 for 1 cycle and the load is written that cycle; the held ALU result is written the next cycle.
